muldiv_reservation_station: RTL and testbench
=============================================

MULDIV_RESERVATION_STATION -- requirements
Module: muldiv_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port flush, input, 1 bit: mispredict flush; kills all held entries.
REQ-005 SHALL have port dispatch_valid, input, 1 bit: dispatch writes dispatch_entry this cycle.
REQ-006 SHALL have port dispatch_entry, input, reservation_station_entry_t: the decoded M-extension op.
REQ-007 SHALL have port dispatch_rs1_ready / dispatch_rs2_ready, input, 1 bit each: source physical register already written.
REQ-008 SHALL have port rs_full, output, 1 bit: all DEPTH entries occupied; combinational.
REQ-009 SHALL have port cdb_valid, input, 1 bit: result broadcast valid.
REQ-010 SHALL have port cdb_phys_rd, input, PHYS_REG_BITS: broadcast destination tag.
REQ-011 SHALL have port unit_done, input, 1 bit: the mul/div unit's execute_valid output.
REQ-012 SHALL have port issue_valid, output, 1 bit: drives the unit's execute_valid_mul.
REQ-013 SHALL have port issue_entry, output, reservation_station_entry_t: drives the unit's line_to_execute_mul and the register-file read tags.

Function
REQ-014 SHALL keep per-entry state: valid, rs1_rdy, rs2_rdy, payload.
REQ-015 SHALL write a dispatch into the lowest-index free entry; a dispatch while rs_full is dropped and SHALL leave the state unchanged.
REQ-016 SHALL, on cdb_valid, set rsN_rdy in every valid entry whose phys_rsN equals cdb_phys_rd; a tag of 0 never matches.
REQ-017 SHALL set the ready bit on dispatch when the dispatch tag matches the same-cycle CDB broadcast (no lost wakeup).
REQ-018 SHALL use a two-state FSM, IDLE and BUSY.
REQ-019 SHALL, in IDLE with at least one entry having valid && rs1_rdy && rs2_rdy, move the lowest-index such entry into the issue register, free its slot, and go to BUSY in the next cycle.
REQ-020 SHALL hold issue_entry constant from the issue cycle until the cycle after unit_done.
REQ-021 SHALL drive issue_valid as follows: for divide ops (funct3[2]=1), high exactly one cycle, the first BUSY cycle; for multiply ops (funct3[2]=0), high from the first BUSY cycle through the cycle unit_done is high inclusive.
REQ-022 SHALL go from BUSY to IDLE on unit_done; the next issue is no earlier than the following cycle, so back-to-back ops have a one-cycle gap.
REQ-023 SHALL treat unit_done in IDLE as spurious and ignore it.
REQ-024 SHALL allow the freed slot to be reused by a dispatch in the same cycle as its issue only from the next cycle; rs_full reflects the pre-issue occupancy.
REQ-025 SHALL, on flush, clear all valid bits, return to IDLE, and drop issue_valid in the same clock edge; a dispatch or CDB in the flush cycle is discarded.
REQ-026 SHALL drive issue_entry to all zeros while IDLE.

Reset
REQ-027 SHALL, on rst, set the FSM to IDLE, clear all valid and ready bits and the issue register, and drive issue_valid=0 and rs_full=0 from the first cycle after reset.
REQ-028 SHALL, on rst asserted mid-operation in BUSY, abandon the op; the unit is reset by the same rst.

Structure
REQ-029 SHALL take reservation_station_entry_t, PHYS_REG_BITS and the op_b_reg encoding from rv32i_types; no new package types.
REQ-030 SHALL contain one sub-module, muldiv_rs_select: a lowest-index priority encoder used for both free-slot and ready-slot selection.

Verification
REQ-031 Reset then dispatch MUL with both sources ready -> issue_valid rises 2 cycles after dispatch, held until unit_done, then 0.
REQ-032 Dispatch DIVU with rs2 tag 12 not ready; CDB tag 12 arrives 5 cycles later -> one-cycle issue_valid pulse the cycle after the BUSY transition, not before.
REQ-033 Fill 4 entries -> rs_full=1; a 5th dispatch is dropped; after one issue and its unit_done, rs_full=0 and the 5th dispatch is accepted.
REQ-034 Dispatch with rs1 tag 7 in the same cycle as a CDB broadcast of tag 7 -> entry issues without any further wakeup.
REQ-035 Flush while BUSY with 3 entries held -> next cycle issue_valid=0, rs_full=0, and no issue occurs for 10 cycles.
REQ-036 Two ready entries at slots 1 and 3 -> slot 1 issues first, and slot 3 issues exactly 1 cycle after unit_done.

Source files
------------

// File: rtl/muldiv_reservation_station_pkg.sv
// Constants and helpers shared by the mul/div reservation station files.
package muldiv_reservation_station_pkg;
  import rv32i_types::*;

  // funct3[2] separates DIV/DIVU/REM/REMU from the MUL family.
  localparam int unsigned FUNCT3_DIV_BIT = 2;

  localparam logic [PHYS_REG_BITS-1:0] PHYS_REG_ZERO = '0;

  // Physical register 0 is hard-wired, so a broadcast of tag 0 wakes nobody.
  function automatic logic tag_hit(input logic [PHYS_REG_BITS-1:0] bcast,
                                   input logic [PHYS_REG_BITS-1:0] src);
    return (bcast != PHYS_REG_ZERO) && (bcast == src);
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I back-end types: physical register tags and the reservation
// station entry layout used by every issue queue.
package rv32i_types;

  localparam int unsigned PHYS_REG_BITS = 6;
  localparam int unsigned ROB_IDX_BITS  = 4;

  typedef enum logic {
    op_b_imm = 1'b0,
    op_b_reg = 1'b1
  } op_b_sel_t;

  typedef struct packed {
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [PHYS_REG_BITS-1:0] phys_rd;
    logic [PHYS_REG_BITS-1:0] phys_rs1;
    logic [PHYS_REG_BITS-1:0] phys_rs2;
    op_b_sel_t                op_b_sel;
    logic [ROB_IDX_BITS-1:0]  rob_idx;
  } reservation_station_entry_t;

endpackage

// File: rtl/muldiv_rs_select.sv
// Lowest-index priority encoder; used for both free-slot and ready-slot picks.
module muldiv_rs_select #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         req,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/muldiv_reservation_station.sv
// Reservation station for the M-extension unit: holds dispatched ops until both
// sources are ready, then hands them one at a time to the shared mul/div unit.
module muldiv_reservation_station
  import rv32i_types::*;
  import muldiv_reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  input  reservation_station_entry_t dispatch_entry,
  input  logic                       dispatch_rs1_ready,
  input  logic                       dispatch_rs2_ready,
  output logic                       rs_full,
  input  logic                       cdb_valid,
  input  logic [PHYS_REG_BITS-1:0]   cdb_phys_rd,
  input  logic                       unit_done,
  output logic                       issue_valid,
  output reservation_station_entry_t issue_entry
);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0]           valid_q;
  logic [DEPTH-1:0]           rs1_rdy_q;
  logic [DEPTH-1:0]           rs2_rdy_q;
  reservation_station_entry_t payload_q [DEPTH];
  reservation_station_entry_t issue_q;
  logic                       first_q;

  logic [DEPTH-1:0] free_req;
  logic [DEPTH-1:0] ready_req;
  logic             free_found;
  logic             ready_found;
  logic [IdxW-1:0]  free_idx;
  logic [IdxW-1:0]  ready_idx;
  logic             do_issue;
  logic             do_dispatch;

  assign free_req  = ~valid_q;
  assign ready_req = valid_q & rs1_rdy_q & rs2_rdy_q;

  muldiv_rs_select #(
    .WIDTH(DEPTH)
  ) u_free_sel (
    .req  (free_req),
    .found(free_found),
    .idx  (free_idx)
  );

  muldiv_rs_select #(
    .WIDTH(DEPTH)
  ) u_ready_sel (
    .req  (ready_req),
    .found(ready_found),
    .idx  (ready_idx)
  );

  // Occupancy before this cycle's issue; a slot freed now is reusable next cycle.
  assign rs_full     = !free_found;
  assign do_issue    = (state_q == StIdle) && ready_found && !flush;
  assign do_dispatch = dispatch_valid && free_found && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ready_found) state_d = StBusy;
      StBusy:  if (unit_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Divides need only a one-cycle start pulse; multiplies keep valid until done.
  always_comb begin
    issue_valid = 1'b0;
    issue_entry = '0;
    if (state_q == StBusy) begin
      issue_valid = first_q || !issue_q.funct3[FUNCT3_DIV_BIT];
      issue_entry = issue_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      issue_q   <= '0;
      first_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      issue_q <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= do_issue;
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && tag_hit(cdb_phys_rd, payload_q[i].phys_rs1)) rs1_rdy_q[i] <= 1'b1;
          if (valid_q[i] && tag_hit(cdb_phys_rd, payload_q[i].phys_rs2)) rs2_rdy_q[i] <= 1'b1;
        end
      end
      if (do_issue) begin
        valid_q[ready_idx] <= 1'b0;
        issue_q            <= payload_q[ready_idx];
      end
      // Same-cycle broadcast must be folded in here or the wakeup is lost.
      if (do_dispatch) begin
        valid_q[free_idx]   <= 1'b1;
        payload_q[free_idx] <= dispatch_entry;
        rs1_rdy_q[free_idx] <= dispatch_rs1_ready ||
                               (cdb_valid && tag_hit(cdb_phys_rd, dispatch_entry.phys_rs1));
        rs2_rdy_q[free_idx] <= dispatch_rs2_ready ||
                               (cdb_valid && tag_hit(cdb_phys_rd, dispatch_entry.phys_rs2));
      end
    end
  end

endmodule

// File: tb/tb_muldiv_reservation_station.sv
// Scoreboard bench: stimulus pushes hand-computed issues, a negedge monitor
// with a simple mul/div unit model pops and compares them.
module tb_muldiv_reservation_station;
  import rv32i_types::*;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic                       dispatch_valid;
  reservation_station_entry_t dispatch_entry;
  logic                       dispatch_rs1_ready;
  logic                       dispatch_rs2_ready;
  logic                       rs_full;
  logic                       cdb_valid;
  logic [PHYS_REG_BITS-1:0]   cdb_phys_rd;
  logic                       unit_done;
  logic                       issue_valid;
  reservation_station_entry_t issue_entry;

  muldiv_reservation_station #(
    .DEPTH(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_entry    (dispatch_entry),
    .dispatch_rs1_ready(dispatch_rs1_ready),
    .dispatch_rs2_ready(dispatch_rs2_ready),
    .rs_full           (rs_full),
    .cdb_valid         (cdb_valid),
    .cdb_phys_rd       (cdb_phys_rd),
    .unit_done         (unit_done),
    .issue_valid       (issue_valid),
    .issue_entry       (issue_entry)
  );

  typedef struct {
    reservation_station_entry_t e;
    int                         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   unit_lat = 3;
  int   unit_left = 0;
  logic unit_active = 1'b0;
  logic op_active = 1'b0;
  logic post_op = 1'b0;
  logic iv_prev = 1'b0;
  logic spurious_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, req);
    end
  endtask

  function automatic reservation_station_entry_t mk(input logic [2:0] f3, input int rd,
                                                    input int rs1, input int rs2, input int rob);
    reservation_station_entry_t e;
    e.opcode   = 7'b0110011;
    e.funct3   = f3;
    e.funct7   = 7'b0000001;
    e.phys_rd  = PHYS_REG_BITS'(rd);
    e.phys_rs1 = PHYS_REG_BITS'(rs1);
    e.phys_rs2 = PHYS_REG_BITS'(rs2);
    e.op_b_sel = op_b_reg;
    e.rob_idx  = ROB_IDX_BITS'(rob);
    return e;
  endfunction

  task automatic push_exp(input reservation_station_entry_t e, input int at);
    exp_t x;
    x.e   = e;
    x.cyc = at;
    exp_q.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
    spurious_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic disp(input reservation_station_entry_t e, input logic r1, input logic r2);
    dispatch_valid     = 1'b1;
    dispatch_entry     = e;
    dispatch_rs1_ready = r1;
    dispatch_rs2_ready = r2;
  endtask

  task automatic bcast(input int tag);
    cdb_valid   = 1'b1;
    cdb_phys_rd = PHYS_REG_BITS'(tag);
  endtask

  // Unit model plus scoreboard monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    unit_done = spurious_done;
    if (rst || flush) begin
      unit_active = 1'b0;
      op_active   = 1'b0;
      post_op     = 1'b0;
    end else begin
      if (unit_active) begin
        if (unit_left == 0) begin
          unit_done   = 1'b1;
          unit_active = 1'b0;
        end else begin
          unit_left--;
        end
      end else if (issue_valid) begin
        unit_active = 1'b1;
        unit_left   = unit_lat - 1;
      end
      if (post_op) begin
        check("valid_after_done", 64'(issue_valid), 64'd0);
        check("entry_zero_idle", 64'(issue_entry), 64'd0);
        post_op = 1'b0;
      end
      if (issue_valid && !iv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 64'(issue_entry), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          check("issue_cycle", 64'(cyc), 64'(cur.cyc));
          check("issue_entry", 64'(issue_entry), 64'(cur.e));
          op_active = 1'b1;
        end
      end else if (op_active) begin
        check("entry_hold", 64'(issue_entry), 64'(cur.e));
        check("valid_level", 64'(issue_valid), 64'(!cur.e.funct3[2]));
      end
      if (op_active && unit_done) begin
        op_active = 1'b0;
        post_op   = 1'b1;
      end
    end
    iv_prev = issue_valid;
  end

  initial begin
    int c;
    reservation_station_entry_t ea, eb, ec, ed, ee;
    rst = 1'b1;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_entry = '0;
    dispatch_rs1_ready = 1'b0;
    dispatch_rs2_ready = 1'b0;
    cdb_valid = 1'b0;
    cdb_phys_rd = '0;
    unit_done = 1'b0;
    idle(3);
    rst = 1'b0;
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_rs_full", 64'(rs_full), 64'd0);
    check("reset_issue_entry", 64'(issue_entry), 64'd0);

    // MUL with both sources ready: valid two cycles after dispatch.
    unit_lat = 3;
    next_cycle();
    c = cyc;
    ea = mk(3'b000, 5, 1, 2, 1);
    disp(ea, 1'b1, 1'b1);
    push_exp(ea, c + 2);
    idle(8);

    // DIVU waiting on tag 12, woken five cycles later.
    next_cycle();
    c = cyc;
    ea = mk(3'b101, 6, 3, 12, 2);
    disp(ea, 1'b1, 1'b0);
    push_exp(ea, c + 7);
    idle(5);
    bcast(12);
    idle(8);

    // Fill, drop when full, reuse the freed slot (lower index wins later).
    unit_lat = 2;
    next_cycle();
    c = cyc;
    ea = mk(3'b000, 8, 20, 4, 3);
    eb = mk(3'b000, 9, 20, 4, 4);
    ec = mk(3'b100, 10, 20, 4, 5);
    ed = mk(3'b001, 11, 20, 4, 6);
    ee = mk(3'b000, 12, 1, 2, 7);
    push_exp(ea, c + 7);
    push_exp(eb, c + 11);
    push_exp(ee, c + 15);
    push_exp(ec, c + 19);
    push_exp(ed, c + 23);
    disp(ea, 1'b0, 1'b1);
    next_cycle();
    disp(eb, 1'b0, 1'b1);
    next_cycle();
    disp(ec, 1'b0, 1'b1);
    next_cycle();
    disp(ed, 1'b0, 1'b1);
    next_cycle();
    check("full_after_four", 64'(rs_full), 64'd1);
    disp(ee, 1'b1, 1'b1);
    next_cycle();
    check("full_after_drop", 64'(rs_full), 64'd1);
    bcast(20);
    next_cycle();
    check("full_in_issue_cycle", 64'(rs_full), 64'd1);
    next_cycle();
    check("not_full_after_issue", 64'(rs_full), 64'd0);
    idle(3);
    disp(ee, 1'b1, 1'b1);
    idle(17);

    // Same-cycle wakeup on dispatch, plus a spurious unit_done while idle.
    unit_lat = 1;
    next_cycle();
    c = cyc;
    ea = mk(3'b011, 9, 7, 5, 8);
    disp(ea, 1'b0, 1'b1);
    bcast(7);
    push_exp(ea, c + 2);
    next_cycle();
    spurious_done = 1'b1;
    idle(5);

    // Flush while busy with three entries held.
    unit_lat = 20;
    next_cycle();
    c = cyc;
    ea = mk(3'b000, 10, 1, 2, 9);
    disp(ea, 1'b1, 1'b1);
    push_exp(ea, c + 2);
    next_cycle();
    disp(mk(3'b000, 13, 30, 2, 10), 1'b0, 1'b1);
    next_cycle();
    disp(mk(3'b100, 14, 30, 2, 11), 1'b0, 1'b1);
    next_cycle();
    disp(mk(3'b000, 15, 30, 2, 12), 1'b0, 1'b1);
    next_cycle();
    flush = 1'b1;
    disp(mk(3'b000, 16, 1, 2, 13), 1'b1, 1'b1);
    bcast(30);
    next_cycle();
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_rs_full", 64'(rs_full), 64'd0);
    check("flush_issue_entry", 64'(issue_entry), 64'd0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("no_issue_after_flush", 64'(issue_valid), 64'd0);
    end
    unit_lat = 2;
    bcast(30);
    next_cycle();
    c = cyc;
    ea = mk(3'b010, 17, 1, 2, 14);
    disp(ea, 1'b1, 1'b1);
    push_exp(ea, c + 2);
    idle(8);

    // Ready entries at slots 1 and 3: slot 1 first, slot 3 one cycle after done.
    unit_lat = 2;
    next_cycle();
    c = cyc;
    eb = mk(3'b000, 18, 41, 2, 1);
    ed = mk(3'b110, 19, 41, 2, 2);
    push_exp(eb, c + 6);
    push_exp(ed, c + 10);
    disp(mk(3'b000, 20, 40, 2, 3), 1'b0, 1'b1);
    next_cycle();
    disp(eb, 1'b0, 1'b1);
    next_cycle();
    disp(mk(3'b000, 21, 40, 2, 4), 1'b0, 1'b1);
    next_cycle();
    disp(ed, 1'b0, 1'b1);
    next_cycle();
    bcast(41);
    idle(10);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
